mdu_scheduler: RTL and testbench
================================

// Module: mdu_scheduler
// PURPOSE
// - Multi-cycle multiply/divide scheduler that owns the HI/LO registers; sits in the EX stage beside the ALU.
// - Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and sequences each one.
// - Exposes HI/LO to the MFHI/MFLO result mux.
// - Raises a stall request to the hazard unit while a HI/LO consumer sits in ID.
// PARAMETERS
// - WIDTH       32  operand / HI / LO width
// - MUL_CYCLES  5   busy cycles for MULT/MULTU (>=1)
// PORTS
// - clk         in   1      system clock; single clock domain, rising edge
// - reset       in   1      synchronous, active-high
// - start       in   1      EX holds a valid, non-flushed MDU instruction this cycle
// - op          in   3      mdu_op_t: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
// - src_a       in   WIDTH  rs value (already forwarded)
// - src_b       in   WIDTH  rt value (already forwarded)
// - hilo_use_d  in   1      ID holds MFHI/MFLO/MTHI/MTLO/MULT*/DIV*
// - hi          out  WIDTH  HI register
// - lo          out  WIDTH  LO register
// - busy        out  1      an operation is in flight
// - stall_req   out  1      to hazard unit: freeze PC and IF/ID, bubble ID/EX
// BEHAVIOUR
// - Reset: state=IDLE, hi=0, lo=0, busy=0, cnt=0. Reset mid-operation abandons it; HI/LO still go to 0.
// - Accept: start=1 with busy=0 at cycle T accepts op. start=1 while busy=1 is ignored.
//   - The hazard unit guarantees this case never arises, via stall_req.
// - MTHI/MTLO: hi (or lo) <= src_a at the edge ending T. No busy cycles. Other register unchanged.
// - MULT/MULTU: product latched at T; busy=1 for cycles T+1..T+MUL_CYCLES.
//   - {hi,lo} <= 64-bit product at the edge ending T+MUL_CYCLES.
//   - busy=0 and the new value is visible at T+MUL_CYCLES+1.
//   - MULT is signed x signed; MULTU is unsigned.
// - DIV/DIVU: operands latched at T. State DIV runs 32 restoring iterations (cycles T+1..T+32); FIX runs 1 cycle (T+33).
//   - FIX applies signs: quotient negated if sign(a)^sign(b); remainder takes sign(a).
//   - lo <= quotient and hi <= remainder at the edge ending T+33; busy=0 at T+34.
//   - DIVU skips the sign logic but keeps the same 33-cycle latency.
// - Divide by zero (src_b==0): normal 33-cycle latency; hi and lo left unchanged.
// - FSM transitions:
//   - IDLE -> MUL on start & MULT*; IDLE -> DIV on start & DIV*; IDLE -> IDLE otherwise.
//   - MUL -> IDLE when cnt==MUL_CYCLES-1.
//   - DIV -> FIX when cnt==31; FIX -> IDLE.
// - cnt: clears on accept, increments in MUL/DIV, never wraps. It is 6 bits; MUL_CYCLES must be <=63.
// - stall_req = hilo_use_d & (busy | (start & op in {MULT,MULTU,DIV,DIVU})). Combinational, no latency.
// - The stall covers the ID instruction during the accept cycle and through the last busy cycle.
// - MFHI/MFLO in EX during cycle T+N+1 read the committed hi/lo directly. No internal bypass is needed.
// - op=NONE with start=1: no state change.
// - Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0. Natural result of the iteration; no trap.
// STRUCTURE
// - Shared package mdu_pkg:
//   - mdu_op_t encodings
//   - state encodings IDLE/MUL/DIV/FIX
//   - DIV_ITERS=32
// - Sub-module mdu_div_iter (unsigned restoring divider):
//   - ports: clk, reset, load, dividend, divisor, quotient, remainder
//   - one quotient bit per cycle
//   - scheduler feeds it absolute values and applies signs in FIX
// - The multiplier is a behavioural '*' result held in a pending register; the scheduler only times its commit.
// TESTING
// - MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> hi=0x12345678, lo=0x9ABCDEF0, busy never 1.
// - MULT 0xFFFFFFFF x 0x2 -> after 5 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//   - MULTU with the same operands -> hi=0x1, lo=0xFFFFFFFE.
// - DIV -7 / 2 -> busy 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
// - MULT followed by MFLO in ID -> stall_req=1 from the accept cycle through the last busy cycle.
//   - MFLO reaches EX exactly one cycle after busy falls and reads the new lo.
// - DIV x/0 with hi=0xAA, lo=0xBB -> after 33 cycles hi=0xAA, lo=0xBB.
//   - Second start asserted while busy -> ignored; state trace unchanged.
// - reset=1 in DIV at iteration 10 -> next cycle state=IDLE, busy=0, hi=lo=0.
//   - A new MULT 3x4 then completes: lo=12, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: instruction encodings, scheduler
// states and the divider iteration count.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 6;

  function automatic logic is_mul_op(input mdu_op_t o);
    return (o == OP_MULT) || (o == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input mdu_op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Unsigned restoring divider: one quotient bit per clock after load.
// Results are valid WIDTH cycles after the load edge.
module mdu_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   trial;

  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};
    quo_d = quo_q;
    rem_d = rem_q;
    dsr_d = dsr_q;
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dsr_d = divisor;
    end else if (!trial[WIDTH]) begin
      // Partial remainder covers the divisor: keep the difference, quotient bit 1.
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu_scheduler.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; commits results after a fixed
// latency and asks the hazard unit to stall HI/LO consumers meanwhile.
module mdu_scheduler
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_use_d,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_req
);

  mdu_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic               accept, mul_last, div_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;

  assign accept     = start & (state_q == ST_IDLE);
  assign mul_last   = (state_q == ST_MUL) && (cnt_q == CNT_W'(MUL_CYCLES - 1));
  assign div_signed = (op == OP_DIV);
  assign a_neg      = div_signed & src_a[WIDTH-1];
  assign b_neg      = div_signed & src_b[WIDTH-1];
  assign abs_a      = a_neg ? -src_a : src_a;
  assign abs_b      = b_neg ? -src_b : src_b;

  mdu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (accept & is_div_op(op)),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mul_op(op)) begin
          state_d = ST_MUL;
          cnt_d   = '0;
        end else if (accept && is_div_op(op)) begin
          state_d = ST_DIV;
          cnt_d   = '0;
        end
      end
      ST_MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (mul_last) state_d = ST_IDLE;
      end
      ST_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = ST_FIX;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    stall_req = hilo_use_d & (busy | (start & (is_mul_op(op) | is_div_op(op))));
  end

  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    prod_d     = prod_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    if (accept) begin
      case (op)
        OP_MTHI:  hi_d = src_a;
        OP_MTLO:  lo_d = src_a;
        // Sign-extending to full product width makes the low 2*WIDTH bits signed-correct.
        OP_MULT:  prod_d = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
        OP_MULTU: prod_d = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
        OP_DIV, OP_DIVU: begin
          neg_quo_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = (src_b == '0);
        end
        default: ;
      endcase
    end
    if (mul_last) {hi_d, lo_d} = prod_q;
    if ((state_q == ST_FIX) && !div_zero_q) begin
      lo_d = neg_quo_q ? -quo : quo;
      hi_d = neg_rem_q ? -rem : rem;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    prod_q     <= prod_d;
    neg_quo_q  <= neg_quo_d;
    neg_rem_q  <= neg_rem_d;
    div_zero_q <= div_zero_d;
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Bench for mdu_scheduler: directed table, hand-written hazard/reset sequences
// and random traffic, all checked against a latency-level reference model.
module tb_mdu_scheduler;
  import mdu_pkg::*;

  localparam int MULC = 5;
  localparam int DIVC = 33;

  logic        clk = 1'b0;
  logic        reset, start, hilo_use_d;
  mdu_op_t     op;
  logic [31:0] src_a, src_b, hi, lo;
  logic        busy, stall_req;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: HI/LO, cycles of busy left, and the pending result.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;
  logic        m_pwrite;

  mdu_scheduler #(.WIDTH(32), .MUL_CYCLES(MULC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .hilo_use_d (hilo_use_d),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: act=%h req=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic long_op(input mdu_op_t o);
    return o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  // Architectural effect of an accepted op, computed with plain arithmetic.
  task automatic model_accept(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      OP_MULT: begin
        p = 64'(sa * sb);
        {m_phi, m_plo} = p; m_pwrite = 1'b1; m_left = MULC;
      end
      OP_MULTU: begin
        p = 64'(a) * 64'(b);
        {m_phi, m_plo} = p; m_pwrite = 1'b1; m_left = MULC;
      end
      OP_DIV: begin
        m_left = DIVC; m_pwrite = (b != 0);
        if (b != 0) begin
          sq = sa / sb; sr = sa % sb;
          m_plo = sq[31:0]; m_phi = sr[31:0];
        end
      end
      OP_DIVU: begin
        m_left = DIVC; m_pwrite = (b != 0);
        if (b != 0) begin
          m_plo = a / b; m_phi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // One clock: drive inputs, check all outputs mid-cycle, advance model at the edge.
  task automatic step(input logic st, input mdu_op_t o, input logic [31:0] a,
                      input logic [31:0] b, input logic use_d, input logic rst,
                      output logic stall_o);
    logic eb, es;
    start = st; op = o; src_a = a; src_b = b; hilo_use_d = use_d; reset = rst;
    @(negedge clk);
    eb = (m_left > 0);
    es = use_d & (eb | (st & long_op(o)));
    chk("busy", 32'(busy), 32'(eb));
    chk("stall_req", 32'(stall_req), 32'(es));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    stall_o = stall_req;
    @(posedge clk);
    if (rst) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_pwrite = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pwrite) begin
        m_hi = m_phi; m_lo = m_plo;
      end
    end else if (st) begin
      model_accept(o, a, b);
    end
    #1;
  endtask

  typedef struct {
    mdu_op_t     op;
    logic [31:0] a, b, exp_hi, exp_lo;
    int          exp_busy;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic s;
    int   cnt, scnt;
    logic [31:0] ra, rb;
    mdu_op_t ro;

    vecs[0]  = '{OP_MTHI,  32'h12345678, 32'h0, 32'h12345678, 32'h00000000, 0};
    vecs[1]  = '{OP_MTLO,  32'h9ABCDEF0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 0};
    vecs[2]  = '{OP_MULT,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, MULC};
    vecs[3]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, MULC};
    vecs[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIVC};
    vecs[5]  = '{OP_DIVU,  32'd100,      32'd7, 32'd2,        32'd14,       DIVC};
    vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DIVC};
    vecs[7]  = '{OP_DIV,   32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIVC};
    vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0, MULC};
    vecs[9]  = '{OP_MTHI,  32'hAA, 32'h0, 32'hAA, 32'h0, 0};
    vecs[10] = '{OP_MTLO,  32'hBB, 32'h0, 32'hAA, 32'hBB, 0};
    vecs[11] = '{OP_DIV,   32'd5, 32'h0, 32'hAA, 32'hBB, DIVC};
    vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'h0, 32'hAA, 32'hBB, DIVC};

    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_left = 0; m_pwrite = 1'b0;
    reset = 1'b1; start = 1'b0; op = OP_NONE; src_a = '0; src_b = '0; hilo_use_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 13; i++) begin
      step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, s);
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
        step(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0, s);
        cnt++;
      end
      chk($sformatf("vec%0d_busy_cycles", i), 32'(cnt), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // MULT with MFLO waiting in ID, then MFLO in EX one cycle after busy falls.
    scnt = 0;
    step(1'b1, OP_MULT, 32'd3, 32'd5, 1'b1, 1'b0, s);
    scnt += int'(s);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      step(1'b0, OP_NONE, 32'h0, 32'h0, 1'b1, 1'b0, s);
      scnt += int'(s);
      cnt++;
    end
    chk("mflo_stall_cycles", 32'(scnt), 32'(MULC + 1));
    chk("mflo_reads_new_lo", lo, 32'd15);
    step(1'b0, OP_NONE, 32'h0, 32'h0, 1'b1, 1'b0, s);
    chk("mflo_stall_released", 32'(s), 32'h0);

    // Divide by zero with a second start ignored while busy.
    step(1'b1, OP_MTHI, 32'hAA, 32'h0, 1'b0, 1'b0, s);
    step(1'b1, OP_MTLO, 32'hBB, 32'h0, 1'b0, 1'b0, s);
    step(1'b1, OP_DIV, 32'd9, 32'h0, 1'b0, 1'b0, s);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      if (cnt == 4) step(1'b1, OP_MULT, 32'd6, 32'd7, 1'b0, 1'b0, s);
      else          step(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0, s);
      cnt++;
    end
    chk("div0_busy_cycles", 32'(cnt), 32'(DIVC));
    chk("div0_hi", hi, 32'hAA);
    chk("div0_lo", lo, 32'hBB);

    // Reset in the middle of a divide, then a fresh multiply.
    step(1'b1, OP_DIV, 32'd1000, 32'd3, 1'b0, 1'b0, s);
    repeat (10) step(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0, s);
    step(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0, 1'b1, s);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    step(1'b1, OP_MULT, 32'd3, 32'd4, 1'b0, 1'b0, s);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      step(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0, s);
      cnt++;
    end
    chk("post_rst_mul_cycles", 32'(cnt), 32'(MULC));
    chk("post_rst_mul_lo", lo, 32'd12);
    chk("post_rst_mul_hi", hi, 32'd0);

    // Random traffic, including starts while busy and occasional zero divisors.
    for (int i = 0; i < 600; i++) begin
      ro = mdu_op_t'($urandom_range(0, 6));
      case ($urandom_range(0, 5))
        0:       ra = 32'h80000000;
        1:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      if (m_left > 0)
        step(($urandom_range(0, 9) == 0), ro, ra, rb, 1'($urandom_range(0, 1)), 1'b0, s);
      else
        step(($urandom_range(0, 4) != 0), ro, ra, rb, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 199) == 0), s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
